spi_target_regs: RTL and testbench
==================================

Name: spi_target_regs

Overview:
- SPI responder (target) at the far end of the SPI master link. Decodes command/address/data frames from the master, holds a small 8-bit register file, and returns register contents on MISO for reads.
- Used as the peripheral model behind each SPI master instance, and as the endpoint that supplies read data back toward the APB bridge path.
- All logic runs in the system clock domain. SCLK, CS_N and MOSI are oversampled and treated as data inputs, not as clocks.

Parameters:
- DEPTH, 16, number of 8-bit registers. Must be ≤128.
- RESET_VAL, 8'h00, reset value of every register.
- SYNC_STAGES, 2, synchronizer depth on sclk/cs_n/mosi. Must be ≥2.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- sclk  input  1  SPI clock from master; mode 0 (CPOL=0, CPHA=0)
- cs_n  input  1  SPI chip select, active-low
- mosi  input  1  master-out data, MSB first
- miso  output  1  target-out data, MSB first
- miso_oe  output  1  high while cs_n is low; enables the tri-state driver at top level
- wr_pulse  output  1  one-clk pulse when a register is written
- wr_addr  output  7  offset of the last write
- wr_data  output  8  data of the last write
- frame_err  output  1  one-clk pulse on an aborted frame or an out-of-range access
- host_addr  input  7  local debug read address
- host_data  output  8  combinational read of regs[host_addr]; 0 if host_addr ≥ DEPTH

Behaviour:
- Reset values: regs = RESET_VAL; miso, miso_oe, wr_pulse, frame_err = 0; wr_addr, wr_data = 0; FSM in IDLE.
- Reset is asynchronous. Asserting it mid-frame aborts the frame with no write and no frame_err.
- Input conditioning:
  - sclk, cs_n and mosi each pass through SYNC_STAGES flops.
  - rise = sync_sclk & ~prev_sclk; fall = ~sync_sclk & prev_sclk.
  - Required SCLK high and low times are each ≥ SYNC_STAGES+2 clk periods.
- Frame format:
  - Byte 0 is the command: bit7 = 1 for write, 0 for read; bits6:0 = start offset.
  - Bytes 1..N are data.
  - mosi is sampled on rise; miso changes only after fall, or on the cs_n falling edge.
- FSM states: IDLE, CMD, WR_DATA, RD_DATA.
  - IDLE -> CMD: synced cs_n falls. bit_cnt = 0, shift register cleared.
  - CMD: shift mosi on each rise. On the 8th rise, latch rw and addr, then:
    - write: go to WR_DATA.
    - read: go to RD_DATA and load the tx shift register with regs[addr], or 8'h00 if addr ≥ DEPTH.
    - The MSB is driven onto miso on the next fall.
  - WR_DATA: on each 8th rise:
    - addr < DEPTH: write regs[addr], pulse wr_pulse, update wr_addr/wr_data.
    - addr ≥ DEPTH: pulse frame_err and do not write.
    - In both cases, advance addr.
  - RD_DATA: on each fall, shift the next bit out. After the 8th bit's fall, advance addr and reload tx from regs[new addr]; the next byte's MSB appears on that same fall.
  - Any state -> IDLE: synced cs_n rises.
    - If bit_cnt ≠ 0 in WR_DATA or CMD, pulse frame_err and discard the partial byte.
    - Mid-byte abort in RD_DATA is legal; no error.
- Auto-increment: addr = (addr == DEPTH-1) ? 0 : addr+1. Once addr ≥ DEPTH, it stays out of range and is not wrapped.
- Read-after-write in the same clk: host_data shows the new value the cycle after wr_pulse.
- miso = tx_shift[7] while cs_n is low, else 0. miso_oe = ~sync_cs_n.
- cs_n rising coincident with an 8th rise: the rise is processed first (the byte completes), then the frame ends without error.

Decomposition:
- Package spi_pkg holds:
  - typedef state_e {IDLE, CMD, WR_DATA, RD_DATA}
  - localparam CMD_WR_BIT = 7
  - typedef byte_t = logic [7:0]
- Natural sub-module: spi_in_sync. Handles per-signal SYNC_STAGES synchronization plus edge detect, and outputs sync level, rise and fall.
- Register file and FSM stay in spi_target_regs.

Test Plan:
- Single write then read. Frame {0x83, 0xA5}, then frame {0x03, 0x00}:
  - wr_pulse once, wr_addr=3, wr_data=0xA5.
  - Read byte on miso = 0xA5.
  - host_data(3) = 0xA5.
- Burst write with wrap. DEPTH=16, frame {0x8E, 0x11, 0x22, 0x33}:
  - regs[14]=0x11, regs[15]=0x22, regs[0]=0x33.
  - Three wr_pulses with addr 14, 15, 0.
- Burst read. Preload regs[0..2] = 0x10, 0x20, 0x30; frame {0x00, x, x, x}:
  - miso bytes = 0x10, 0x20, 0x30.
  - miso_oe is high only during the frame.
- Out-of-range:
  - Frame {0x95, 0xFF} gives frame_err once, no wr_pulse, regs unchanged.
  - Frame {0x15, x} returns 0x00 on miso.
- Abort and reset:
  - Write frame with cs_n raised after 4 data bits gives frame_err, no write.
  - Asserting reset low during byte 1 of a write clears all regs to RESET_VAL with no wr_pulse.
  - The next frame after reset works normally.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared types for the SPI target register block.
//   state_e    - frame decoder states
//   CMD_WR_BIT - command byte bit selecting write (1) / read (0)
//   byte_t     - 8-bit data type
package spi_pkg;

  typedef enum logic [1:0] {IDLE, CMD, WR_DATA, RD_DATA} state_e;

  localparam int CMD_WR_BIT = 7;

  typedef logic [7:0] byte_t;

endpackage

// File: rtl/spi_target_regs_if.sv
// spi_target_regs_if: SPI pin bundle between a master and the target.
//   sclk, cs_n, mosi : master -> target
//   miso, miso_oe    : target -> master (miso_oe enables the pad driver)
interface spi_target_regs_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sclk, cs_n, mosi, input miso, miso_oe);
  modport slave  (input sclk, cs_n, mosi, output miso, miso_oe);
endinterface

// File: rtl/spi_in_sync.sv
// spi_in_sync: multi-flop synchronizer for one asynchronous SPI pin plus
// rise/fall detection on the synchronized level.
//   clk, rst_n : system clock, async active-low reset
//   i_d        : raw pin
//   o_lvl      : synchronized level
//   o_rise     : one-clk pulse on a 0->1 transition of o_lvl
//   o_fall     : one-clk pulse on a 1->0 transition of o_lvl
module spi_in_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0   // idle level of the pin, so reset release creates no edge
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_lvl  = r_sync[STAGES-1];
  assign o_rise =  r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] &  r_prev;

endmodule

// File: rtl/spi_target_regs.sv
// spi_target_regs: SPI mode-0 target holding DEPTH 8-bit registers.
// Frame = command byte {rw, addr[6:0]} followed by data bytes; the address
// auto-increments per data byte (wrapping at DEPTH-1, out-of-range sticks).
//   clk, reset  : system clock, async active-low reset
//   spi         : SPI pins (slave modport)
//   wr_pulse    : one-clk pulse per register write
//   wr_addr/data: offset/data of the last write
//   frame_err   : one-clk pulse on aborted byte or out-of-range write
//   host_addr   : debug read address
//   host_data   : regs[host_addr], 0 when out of range
module spi_target_regs
  import spi_pkg::*;
#(
  parameter int    DEPTH       = 16,
  parameter byte_t RESET_VAL   = 8'h00,
  parameter int    SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  spi_target_regs_if.slave spi,
  output logic             wr_pulse,
  output logic [6:0]       wr_addr,
  output byte_t            wr_data,
  output logic             frame_err,
  input  logic [6:0]       host_addr,
  output byte_t            host_data
);

  localparam int         AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] DEPTH_B = 8'(DEPTH);
  localparam logic [7:0] LAST_B  = 8'(DEPTH - 1);

  // ---- input conditioning: [0]=sclk [1]=cs_n [2]=mosi ----
  logic [2:0] w_raw, w_lvl, w_rise, w_fall;
  logic       w_unused;

  assign w_raw = {spi.mosi, spi.cs_n, spi.sclk};

  for (genvar g = 0; g < 3; g++) begin : g_sync
    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(g == 1)) u_sync (
      .clk   (clk),
      .rst_n (reset),
      .i_d   (w_raw[g]),
      .o_lvl (w_lvl[g]),
      .o_rise(w_rise[g]),
      .o_fall(w_fall[g])
    );
  end

  assign w_unused = &{1'b0, w_lvl[0], w_rise[2], w_fall[2]};

  // ---- state ----
  state_e                  r_state, w_state;
  logic [2:0]              r_bit_cnt, w_bit_cnt;
  logic [6:0]              r_rx, w_rx;        // bits 7..1 of the byte in flight
  byte_t                   r_tx, w_tx;        // bits still to be driven
  logic [3:0]              r_tx_cnt, w_tx_cnt;
  logic                    r_miso, w_miso;
  logic [6:0]              r_addr, w_addr;
  logic                    w_wr_pulse, w_frame_err, w_we;
  logic [6:0]              w_wr_addr;
  byte_t                   w_wr_data, w_byte, w_rd;
  logic [DEPTH-1:0][7:0]   r_regs;

  function automatic logic f_inrange(input logic [6:0] a);
    return {1'b0, a} < DEPTH_B;
  endfunction

  // Out-of-range addresses hold so they never wrap back into the file.
  function automatic logic [6:0] f_next(input logic [6:0] a);
    if ({1'b0, a} == LAST_B)  return 7'd0;
    else if (f_inrange(a))    return a + 7'd1;
    else                      return a;
  endfunction

  function automatic byte_t f_rd(input logic [6:0] a);
    return f_inrange(a) ? r_regs[a[AW-1:0]] : 8'h00;
  endfunction

  always_comb begin
    w_state     = r_state;
    w_bit_cnt   = r_bit_cnt;
    w_rx        = r_rx;
    w_tx        = r_tx;
    w_tx_cnt    = r_tx_cnt;
    w_miso      = r_miso;
    w_addr      = r_addr;
    w_wr_pulse  = 1'b0;
    w_wr_addr   = wr_addr;
    w_wr_data   = wr_data;
    w_frame_err = 1'b0;
    w_we        = 1'b0;
    w_rd        = 8'h00;
    w_byte      = {r_rx, w_lvl[2]};

    case (r_state)
      IDLE: begin
        if (w_fall[1]) begin
          w_state   = CMD;
          w_bit_cnt = 3'd0;
          w_rx      = 7'd0;
          w_tx      = 8'h00;
          w_tx_cnt  = 4'd0;
          w_miso    = 1'b0;
        end
      end
      CMD, WR_DATA: begin
        if (w_rise[0]) begin
          w_rx      = w_byte[6:0];
          w_bit_cnt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            if (r_state == CMD) begin
              w_addr = w_byte[6:0];
              if (w_byte[CMD_WR_BIT]) begin
                w_state = WR_DATA;
              end else begin
                w_state  = RD_DATA;
                w_tx     = f_rd(w_byte[6:0]);
                w_tx_cnt = 4'd0;
              end
            end else begin
              if (f_inrange(r_addr)) begin
                w_we       = 1'b1;
                w_wr_pulse = 1'b1;
                w_wr_addr  = r_addr;
                w_wr_data  = w_byte;
              end else begin
                w_frame_err = 1'b1;
              end
              w_addr = f_next(r_addr);
            end
          end
        end
      end
      RD_DATA: begin
        // Each fall drives one bit; the fall after bit 0 fetches the next
        // byte and drives its MSB immediately.
        if (w_fall[0]) begin
          if (r_tx_cnt == 4'd8) begin
            w_addr   = f_next(r_addr);
            w_rd     = f_rd(w_addr);
            w_miso   = w_rd[7];
            w_tx     = {w_rd[6:0], 1'b0};
            w_tx_cnt = 4'd1;
          end else begin
            w_miso   = r_tx[7];
            w_tx     = {r_tx[6:0], 1'b0};
            w_tx_cnt = r_tx_cnt + 4'd1;
          end
        end
      end
      default: ;
    endcase

    // Frame end is evaluated after any same-cycle sclk rise, so a byte
    // completing together with cs_n rising is not an error.
    if (r_state != IDLE && w_rise[1]) begin
      w_state = IDLE;
      w_miso  = 1'b0;
      w_tx    = 8'h00;
      if ((r_state == CMD || r_state == WR_DATA) && w_bit_cnt != 3'd0)
        w_frame_err = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bit_cnt <= 3'd0;
      r_rx      <= 7'd0;
      r_tx      <= 8'h00;
      r_tx_cnt  <= 4'd0;
      r_miso    <= 1'b0;
      r_addr    <= 7'd0;
      wr_pulse  <= 1'b0;
      wr_addr   <= 7'd0;
      wr_data   <= 8'h00;
      frame_err <= 1'b0;
      r_regs    <= {DEPTH{RESET_VAL}};
    end else begin
      r_bit_cnt <= w_bit_cnt;
      r_rx      <= w_rx;
      r_tx      <= w_tx;
      r_tx_cnt  <= w_tx_cnt;
      r_miso    <= w_miso;
      r_addr    <= w_addr;
      wr_pulse  <= w_wr_pulse;
      wr_addr   <= w_wr_addr;
      wr_data   <= w_wr_data;
      frame_err <= w_frame_err;
      if (w_we) r_regs[r_addr[AW-1:0]] <= w_byte;
    end
  end

  assign spi.miso    = r_miso & ~w_lvl[1];
  assign spi.miso_oe = ~w_lvl[1];
  assign host_data   = f_rd(host_addr);

endmodule

// File: tb/tb_spi_target_regs.sv
// tb_spi_target_regs: directed + randomized frames against a frame-level
// model of the register file (address walk, read data, expected writes
// and errors per frame).
module tb_spi_target_regs;
  import spi_pkg::*;

  localparam int DEPTH = 16;
  localparam int HALF  = 6;   // sclk half period in clk cycles

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_target_regs_if sif();
  logic       wr_pulse;
  logic [6:0] wr_addr;
  byte_t      wr_data;
  logic       frame_err;
  logic [6:0] host_addr;
  byte_t      host_data;

  spi_target_regs #(.DEPTH(DEPTH), .RESET_VAL(8'h00), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .spi      (sif),
    .wr_pulse (wr_pulse),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .frame_err(frame_err),
    .host_addr(host_addr),
    .host_data(host_data)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // observed events
  logic [14:0] wr_q[$];
  int          err_seen = 0;
  always @(negedge clk) begin
    if (wr_pulse)  wr_q.push_back({wr_addr, wr_data});
    if (frame_err) err_seen++;
  end

  // model state and per-frame expectations
  byte_t       m_regs[DEPTH];
  byte_t       f_tx[$];
  byte_t       f_rx[$];
  byte_t       e_rx[$];
  logic [14:0] e_wr[$];
  int          e_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, output logic m);
    sif.mosi = b;
    wait_clk(HALF);
    m = sif.miso;
    sif.sclk = 1'b1;
    wait_clk(HALF);
    sif.sclk = 1'b0;
  endtask

  // Drives f_tx; the last byte carries last_bits bits. coinc raises cs_n
  // together with the final sclk rise.
  task automatic send_frame(input int last_bits, input bit coinc);
    byte_t rb;
    logic  m;
    f_rx.delete();
    sif.cs_n = 1'b0;
    wait_clk(HALF);
    for (int b = 0; b < f_tx.size(); b++) begin
      int nb;
      nb = (b == f_tx.size() - 1) ? last_bits : 8;
      rb = 8'h00;
      for (int i = 0; i < nb; i++) begin
        if (b == 0 && i == 0) check("miso_oe_in_frame", 32'(sif.miso_oe), 32'd1);
        if (coinc && b == f_tx.size() - 1 && i == nb - 1) begin
          sif.mosi = f_tx[b][7-i];
          wait_clk(HALF);
          m = sif.miso;
          sif.sclk = 1'b1;
          sif.cs_n = 1'b1;
          wait_clk(HALF);
          sif.sclk = 1'b0;
        end else begin
          send_bit(f_tx[b][7-i], m);
        end
        rb = {rb[6:0], m};
      end
      f_rx.push_back(rb);
    end
    if (!coinc) begin
      wait_clk(HALF);
      sif.cs_n = 1'b1;
    end
    wait_clk(2 * HALF);
  endtask

  // Frame-level model: walk the address with integer arithmetic.
  task automatic model_frame(input int last_bits);
    int    n, a;
    bit    wr, full;
    byte_t cmd;
    e_rx.delete();
    e_wr.delete();
    e_err = 0;
    n = f_tx.size();
    if (n == 1 && last_bits < 8) begin
      e_err = 1;
      return;
    end
    cmd = f_tx[0];
    wr  = cmd[7];
    a   = int'(cmd[6:0]);
    e_rx.push_back(8'h00);
    for (int b = 1; b < n; b++) begin
      full = !(b == n - 1 && last_bits < 8);
      if (wr) begin
        if (!full) begin
          e_err++;
          break;
        end
        if (a < DEPTH) begin
          m_regs[a] = f_tx[b];
          e_wr.push_back({7'(a), f_tx[b]});
        end else begin
          e_err++;
        end
      end else if (full) begin
        e_rx.push_back((a < DEPTH) ? m_regs[a] : 8'h00);
      end
      a = (a == DEPTH - 1) ? 0 : a + 1;
    end
  endtask

  task automatic check_host(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      host_addr = 7'(a);
      @(negedge clk);
      check(tag, 32'(host_data), 32'(m_regs[a]));
    end
    host_addr = 7'd20;
    @(negedge clk);
    check({tag, "_oor"}, 32'(host_data), 32'd0);
  endtask

  task automatic run_frame(input string tag, input int last_bits, input bit coinc);
    int  err0;
    bit  is_rd;
    err0  = err_seen;
    is_rd = !f_tx[0][7];
    wr_q.delete();
    model_frame(last_bits);
    send_frame(last_bits, coinc);
    check({tag, "_err"}, 32'(err_seen - err0), 32'(e_err));
    check({tag, "_nwr"}, 32'(wr_q.size()), 32'(e_wr.size()));
    for (int i = 0; i < e_wr.size() && i < wr_q.size(); i++)
      check({tag, "_wr"}, 32'(wr_q[i]), 32'(e_wr[i]));
    if (is_rd)
      for (int i = 0; i < e_rx.size(); i++)
        check({tag, "_rx"}, 32'(f_rx[i]), 32'(e_rx[i]));
    check({tag, "_oe_idle"}, 32'(sif.miso_oe), 32'd0);
    check_host(tag);
  endtask

  initial begin
    logic m;
    int   err0;
    for (int i = 0; i < DEPTH; i++) m_regs[i] = 8'h00;
    reset     = 1'b0;
    sif.sclk  = 1'b0;
    sif.cs_n  = 1'b1;
    sif.mosi  = 1'b0;
    host_addr = 7'd0;
    wait_clk(3);
    check("rst_wr_pulse",  32'(wr_pulse),    32'd0);
    check("rst_frame_err", 32'(frame_err),   32'd0);
    check("rst_miso",      32'(sif.miso),    32'd0);
    check("rst_miso_oe",   32'(sif.miso_oe), 32'd0);
    check("rst_wr_addr",   32'(wr_addr),     32'd0);
    check("rst_wr_data",   32'(wr_data),     32'd0);
    check("rst_host",      32'(host_data),   32'd0);
    reset = 1'b1;
    wait_clk(4);

    // single write then read back
    f_tx = '{8'h83, 8'hA5};                  run_frame("wr1", 8, 1'b0);
    f_tx = '{8'h03, 8'h00};                  run_frame("rd1", 8, 1'b0);
    // burst write wrapping 15 -> 0
    f_tx = '{8'h8E, 8'h11, 8'h22, 8'h33};    run_frame("wrap", 8, 1'b0);
    // preload and burst read
    f_tx = '{8'h80, 8'h10, 8'h20, 8'h30};    run_frame("pre", 8, 1'b0);
    f_tx = '{8'h00, 8'($urandom), 8'($urandom), 8'($urandom)};
    run_frame("brd", 8, 1'b0);
    // out-of-range write and read
    f_tx = '{8'h95, 8'hFF};                  run_frame("oor_wr", 8, 1'b0);
    f_tx = '{8'h15, 8'($urandom)};           run_frame("oor_rd", 8, 1'b0);
    // read across the top of the file
    f_tx = '{8'h0F, 8'h00, 8'h00};           run_frame("rd_wrap", 8, 1'b0);
    // aborts: mid data byte, mid command byte, mid read (legal)
    f_tx = '{8'h83, 8'h5A};                  run_frame("abort_wr", 4, 1'b0);
    f_tx = '{8'h83};                         run_frame("abort_cmd", 3, 1'b0);
    f_tx = '{8'h01, 8'h00};                  run_frame("abort_rd", 5, 1'b0);
    // cs_n rising together with the 8th rise completes the byte
    f_tx = '{8'h85, 8'hC3};                  run_frame("coinc", 8, 1'b1);

    // reset asserted during data byte 1 of a write
    err0 = err_seen;
    wr_q.delete();
    sif.cs_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 8; i++) send_bit(i == 0 || i == 5, m);  // 0x84
    for (int i = 0; i < 3; i++) send_bit(1'b1, m);
    reset    = 1'b0;
    sif.cs_n = 1'b1;
    sif.sclk = 1'b0;
    wait_clk(3);
    reset = 1'b1;
    wait_clk(2 * HALF);
    for (int i = 0; i < DEPTH; i++) m_regs[i] = 8'h00;
    check("mid_rst_nwr", 32'(wr_q.size()), 32'd0);
    check("mid_rst_err", 32'(err_seen - err0), 32'd0);
    check_host("mid_rst_host");

    f_tx = '{8'h82, 8'h9C};                  run_frame("post_rst_wr", 8, 1'b0);
    f_tx = '{8'h02, 8'h00};                  run_frame("post_rst_rd", 8, 1'b0);

    // randomized frames
    for (int k = 0; k < 24; k++) begin
      int nd, lb;
      byte_t cmd;
      cmd = {1'($urandom), 7'($urandom_range(0, 20))};
      nd  = $urandom_range(1, 4);
      lb  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 8;
      f_tx.delete();
      f_tx.push_back(cmd);
      for (int j = 0; j < nd; j++) f_tx.push_back(8'($urandom));
      run_frame("rand", lb, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
